// File: rtl/pair_pack_pkg.sv
// Shared types and helpers for the A/B pair packing FIFO.
package pair_pack_pkg;

    typedef logic [15:0] pair_word_t;

    localparam int PAIR_DEPTH_DEFAULT = 4;

    function automatic pair_word_t pack_pair(input logic [7:0] a, input logic [7:0] b);
        return {a, b};
    endfunction

endpackage

// File: rtl/pair_pack_mem.sv
// DEPTH x 16 storage array: one synchronous write port, one asynchronous read port, no reset.
module pair_pack_mem
    import pair_pack_pkg::*;
#(
    parameter int DEPTH = PAIR_DEPTH_DEFAULT,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  pair_word_t    wdata,
    input  logic [AW-1:0] raddr,
    output pair_word_t    rdata
);

    pair_word_t mem_r [DEPTH];

    // Storage write
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/pair_pack_fifo.sv
// Packs accepted A/B byte pairs into 16-bit words and delivers them from a show-ahead FIFO.
// Optional running XOR checksum of accepted pairs when PAIR_CHECKSUM_EN is defined.
module pair_pack_fifo
    import pair_pack_pkg::*;
#(
    parameter int DEPTH = PAIR_DEPTH_DEFAULT,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_a,
    input  logic [7:0]    in_b,
    output logic          in_ready,
    output logic          out_valid,
    output logic [15:0]   out_data,
    input  logic          out_ready,
    output logic [CW-1:0] count,
`ifdef PAIR_CHECKSUM_EN
    output logic [7:0]    checksum,
`endif
    output logic          drop_seen
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          drop_seen_r;
    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] count_nxt_s;
    pair_word_t    rdata_s;

    // Full/empty come from the registered count only, so out_ready never reaches in_ready.
    assign in_ready  = (count_r != FULL_COUNT);
    assign out_valid = (count_r != {CW{1'b0}});
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;
    assign out_data  = rdata_s;
    assign count     = count_r;
    assign drop_seen = drop_seen_r;

    pair_pack_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (pack_pair(in_a, in_b)),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

    // Next occupancy from the push/pop pair
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and sticky drop flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            drop_seen_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            if (in_valid && !in_ready) begin
                drop_seen_r <= 1'b1;
            end
        end
    end

`ifdef PAIR_CHECKSUM_EN
    logic [7:0] checksum_r;

    // Running XOR over accepted pairs only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum_r <= 8'h00;
        end else if (push_s) begin
            checksum_r <= checksum_r ^ in_a ^ in_b;
        end
    end

    assign checksum = checksum_r;
`endif

endmodule

// File: doc/pair_pack_fifo.md
# pair_pack_fifo

Downstream consumer for the registered nested-priority byte stage. Each cycle, that stage can present an A byte and a B byte. This block packs each accepted pair into a 16-bit word, buffers the words in a small show-ahead FIFO, and delivers them over a valid/ready handshake. It also keeps a sticky drop flag and, optionally, a running XOR checksum of accepted pairs.

## Interface
- DEPTH, default 4: FIFO entries; must be a power of two and at least 2.
- clk  in  1: clock, rising edge.
- reset  in  1: asynchronous, active-high; clock clk.
- in_valid  in  1: the A/B pair is valid this cycle.
- in_a  in  8: A byte; becomes the upper half of the word.
- in_b  in  8: B byte; becomes the lower half of the word.
- in_ready  out  1: the FIFO can accept a pair.
- out_valid  out  1: out_data holds the oldest word.
- out_data  out  16: oldest word, {a,b}.
- out_ready  in  1: the consumer accepts out_data.
- count  out  $clog2(DEPTH)+1: number of words stored.
- drop_seen  out  1: sticky flag; set when in_valid was high while the FIFO was full.
- checksum  out  8: present only with PAIR_CHECKSUM_EN.

## Operation
- Push occurs when in_valid && in_ready. It writes {in_a,in_b} at wr_ptr, then increments wr_ptr modulo DEPTH.
- Pop occurs when out_valid && out_ready. It increments rd_ptr modulo DEPTH.
- in_ready = (count != DEPTH). This is combinational from registered state and never depends on out_ready. There is no push-through when full.
- out_valid = (count != 0). out_data = mem[rd_ptr] (show-ahead read).
- out_data is don't-care while out_valid=0. The bench must not check it then.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full with in_valid=1: the pair is discarded and drop_seen is set. If a pop also occurs that cycle, the pair is still discarded.
- Empty with push: the word is visible on out_valid/out_data from the next cycle. There is no same-cycle bypass.
- Pointers wrap at DEPTH. They are $clog2(DEPTH) bits wide. Full and empty are resolved by count, not by pointer comparison.
- drop_seen is cleared only by reset.
- Asserting reset mid-stream empties the FIFO immediately. Buffered words are lost. mem contents are not reset.

## Timing
- Reset values: in_ready=1, out_valid=0, count=0, drop_seen=0, checksum=8'h00. out_data is undefined.
- Push to out_valid: 1 cycle.
- Pop to the next word on out_data: 1 cycle.
- Throughput: one push and one pop per cycle when neither full nor empty.
- No combinational path from in_* to out_*, and none from out_ready to in_ready.

## Configuration
- PAIR_CHECKSUM_EN defined:
  - checksum port exists.
  - On each push, checksum <= checksum ^ in_a ^ in_b.
  - Discarded pairs do not contribute.
  - Reset value is 0.
- PAIR_CHECKSUM_EN undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- Package pair_pack_pkg holds:
  - typedef pair_word_t (logic [15:0]);
  - localparam PAIR_DEPTH_DEFAULT = 4;
  - function pack_pair(a,b) returning {a,b}.
- Sub-module pair_pack_mem: DEPTH x 16 register array with a write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata). No reset.
- Pointers, count, flags and the checksum stay in pair_pack_fifo.

## Test plan
- Reset release, then push (a=8'h6E, b=8'h7C) for one cycle with out_ready=0:
  - next cycle out_valid=1, out_data=16'h6E7C, count=1;
  - checksum=8'h12 with the macro defined.
- Hold out_ready=0 and push 5 pairs with DEPTH=4:
  - after 4 accepted pushes: count=4, in_ready=0, drop_seen=1;
  - the 5th pair is never output.
- With the FIFO full, hold in_valid=1 and pulse out_ready for one cycle:
  - count goes 4→3;
  - drop_seen stays 1;
  - the next push is accepted one cycle later.
- Continuous push and pop with out_ready=1, values 8'h00..8'h0F in both bytes:
  - outputs 16'h0000, 16'h0101 … 16'h0F0F in order, one cycle behind input;
  - count stays at 1;
  - pointers wrap at least 3 times;
  - checksum=8'h00.
- Assert reset for 1 cycle while count=3:
  - immediately count=0, out_valid=0, in_ready=1, drop_seen=0.
- Empty FIFO, in_valid=1 and out_ready=1 in the same cycle:
  - no pop occurs;
  - count=1 on the next cycle, and the word is popped on that cycle.
